fpu_share_arbiter: RTL and testbench

- Shares one FPU_FSM instance (sign-magnitude 8.8 operands, 2-bit op select S, start/done handshake, 32-bit result) among NREQ requesters.
- Arbitrates round-robin, latches the winner's operands, pulses the FPU start, and waits for done with a watchdog.
- Returns the result, or a timeout error, to the granted requester only.
- Sits between the compute clients and the FPU datapath.

---
 rtl/fpu_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter
//   Shares one FPU (sign-magnitude 8.8 operands, 2-bit op select, start/done
//   handshake, 32-bit result) among NREQ requesters. A round-robin grant is
//   taken in IDLE. The winner's operands are latched and the FPU is started
//   once. A watchdog bounds the wait for done. The result, or a timeout error,
//   is returned only to the granted requester.
//
// Ports
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   req[NREQ]          request levels, held until ack
//   req_op/req_a/req_b packed per-requester op code (2b) and operands (17b)
//   ack[NREQ]          one-hot pulse: operands latched for that requester
//   rsp_valid[NREQ]    one-hot pulse: rsp_result/rsp_err valid for requester
//   rsp_result, rsp_err response payload; held until the next response
//   busy               high whenever the arbiter is not idle
//   fpu_start, fpu_S, fpu_sign_*, fpu_int_*, fpu_frac_*  FPU command side
//   fpu_result, fpu_done                                 FPU completion side
module fpu_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [17*NREQ-1:0]   req_a,
    input  logic [17*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_result,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 fpu_start,
    output logic [1:0]           fpu_S,
    output logic                 fpu_sign_a,
    output logic                 fpu_sign_b,
    output logic [7:0]           fpu_int_a,
    output logic [7:0]           fpu_frac_a,
    output logic [7:0]           fpu_int_b,
    output logic [7:0]           fpu_frac_b,
    input  logic [31:0]          fpu_result,
    input  logic                 fpu_done
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [WW-1:0] wdog;

    logic [IW-1:0] grant;
    logic [IW-1:0] cand;
    logic          grant_ok;
    logic [1:0]    op_arr [NREQ];
    logic [16:0]   a_arr  [NREQ];
    logic [16:0]   b_arr  [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            op_arr[i] = req_op[2*i +: 2];
            a_arr[i]  = req_a[17*i +: 17];
            b_arr[i]  = req_b[17*i +: 17];
        end
    end

    // First requesting index at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        grant    = '0;
        cand     = '0;
        grant_ok = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(ptr) + k) % NREQ);
            if (!grant_ok && req[cand]) begin
                grant    = cand;
                grant_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            wdog       <= '0;
            ack        <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            fpu_start  <= 1'b0;
            fpu_S      <= '0;
            fpu_sign_a <= 1'b0;
            fpu_sign_b <= 1'b0;
            fpu_int_a  <= '0;
            fpu_frac_a <= '0;
            fpu_int_b  <= '0;
            fpu_frac_b <= '0;
        end else begin
            ack       <= '0;
            rsp_valid <= '0;
            fpu_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        fpu_S <= op_arr[grant];
                        {fpu_sign_a, fpu_int_a, fpu_frac_a} <= a_arr[grant];
                        {fpu_sign_b, fpu_int_b, fpu_frac_b} <= b_arr[grant];
                        ack   <= {{(NREQ-1){1'b0}}, 1'b1} << grant;
                        owner <= grant;
                        ptr   <= (grant == IW'(NREQ-1)) ? '0 : grant + 1'b1;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    fpu_start <= 1'b1;
                    wdog      <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // done is tested first so it wins over a coinciding timeout
                    if (fpu_done) begin
                        rsp_result <= fpu_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= {{(NREQ-1){1'b0}}, 1'b1} << owner;
                        state      <= RESP;
                    end else if (wdog == WW'(TIMEOUT-1)) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= {{(NREQ-1){1'b0}}, 1'b1} << owner;
                        state      <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Self-checking bench for fpu_share_arbiter (NREQ=4, TIMEOUT=64).
// A behavioural FPU with programmable latency answers start pulses; a
// round-robin reference picks the expected winner on each ack and pushes the
// expected response into a scoreboard that is popped on rsp_valid.
module tb_fpu_share_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_op;
    logic [67:0] req_a;
    logic [67:0] req_b;
    logic [3:0]  ack;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        busy;
    logic        fpu_start;
    logic [1:0]  fpu_S;
    logic        fpu_sign_a, fpu_sign_b;
    logic [7:0]  fpu_int_a, fpu_frac_a, fpu_int_b, fpu_frac_b;
    logic [31:0] fpu_result = '0;
    logic        fpu_done   = 1'b0;

    logic [1:0]  op_v [4];
    logic [16:0] a_v  [4];
    logic [16:0] b_v  [4];

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            req_op[2*i +: 2]  = op_v[i];
            req_a[17*i +: 17] = a_v[i];
            req_b[17*i +: 17] = b_v[i];
        end
    end

    fpu_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .ack(ack), .rsp_valid(rsp_valid),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
        .fpu_start(fpu_start), .fpu_S(fpu_S),
        .fpu_sign_a(fpu_sign_a), .fpu_sign_b(fpu_sign_b),
        .fpu_int_a(fpu_int_a), .fpu_frac_a(fpu_frac_a),
        .fpu_int_b(fpu_int_b), .fpu_frac_b(fpu_frac_b),
        .fpu_result(fpu_result), .fpu_done(fpu_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Reference FPU arithmetic: op 00 adds magnitudes, other ops mix bits.
    function automatic logic [31:0] fmodel(input logic [1:0] op, input logic [16:0] a, input logic [16:0] b);
        if (op == 2'b00) return 32'(a[15:0]) + 32'(b[15:0]);
        return {op, 13'd0, a ^ b};
    endfunction

    // Behavioural FPU
    int          fpu_delay  = 4;
    logic        fpu_never  = 1'b0;
    logic        stray_done = 1'b0;
    int          m_cnt      = 0;
    logic        m_busy     = 1'b0;
    logic [31:0] m_res      = '0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            m_busy   = 1'b0;
            fpu_done = 1'b0;
        end else begin
            fpu_done = 1'b0;
            if (stray_done) begin
                fpu_done   = 1'b1;
                fpu_result = 32'hDEADBEEF;
            end
            if (fpu_start) begin
                m_busy = 1'b1;
                m_cnt  = fpu_delay;
                m_res  = fmodel(fpu_S, {fpu_sign_a, fpu_int_a, fpu_frac_a},
                                {fpu_sign_b, fpu_int_b, fpu_frac_b});
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    if (!fpu_never) begin
                        fpu_done   = 1'b1;
                        fpu_result = m_res;
                    end
                end
            end
        end
    end

    // Scoreboard and monitor state
    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    int          grants [$];
    logic [1:0]  ptr_m      = '0;
    logic [3:0]  req_edge   = '0;
    logic        hold       = 1'b0;
    logic        prev_start = 1'b0;
    int          cyc        = 0;
    int          start_cyc  = 0;
    int          done_cyc   = -10;
    int          rsp_cnt    = 0;

    function automatic int rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] c;
        for (int unsigned k = 0; k < 4; k++) begin
            c = p + 2'(k);
            if (r[c]) return int'(c);
        end
        return -1;
    endfunction

    task automatic tick();
        int   g;
        exp_t e;
        @(posedge clk);
        req_edge = req;
        @(negedge clk);
        #1;
        cyc++;
        if (fpu_done) done_cyc = cyc;
        if (fpu_start) begin
            check("start_single_cycle", 96'(prev_start), 96'(0));
            start_cyc = cyc;
        end
        prev_start = fpu_start;
        if (ack != 4'b0000) begin
            g = rr_pick(req_edge, ptr_m);
            check("ack_excl_rsp", 96'(rsp_valid), 96'(0));
            if (g < 0) begin
                check("ack_unexpected", 96'(ack), 96'(0));
            end else begin
                check("ack_grant", 96'(ack), 96'(4'b0001 << g));
                e.idx = g;
                e.err = fpu_never || (fpu_delay >= TIMEOUT);
                e.res = e.err ? 32'h0 : fmodel(op_v[g], a_v[g], b_v[g]);
                sb.push_back(e);
                grants.push_back(g);
                ptr_m = 2'(g + 1);
                if (!hold) req[g] = 1'b0;
            end
        end
        if (rsp_valid != 4'b0000) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 96'(rsp_valid), 96'(0));
            end else begin
                e = sb.pop_front();
                check("rsp_idx", 96'(rsp_valid), 96'(4'b0001 << e.idx));
                check("rsp_result", 96'(rsp_result), 96'(e.res));
                check("rsp_err", 96'(rsp_err), 96'(e.err));
                if (e.err) check("rsp_timeout_lat", 96'(cyc - start_cyc), 96'(TIMEOUT));
                else       check("rsp_done_lat", 96'(cyc - done_cyc), 96'(1));
            end
            rsp_cnt++;
        end
    endtask

    task automatic wait_rsp(input int target, input int limit);
        int n = 0;
        while (rsp_cnt < target && n < limit) begin
            tick();
            n++;
        end
        if (rsp_cnt < target) check("wait_rsp_bound", 96'(rsp_cnt), 96'(target));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("reset_outputs_zero",
              96'({ack, rsp_valid, rsp_result, rsp_err, busy, fpu_start, fpu_S,
                   fpu_sign_a, fpu_sign_b, fpu_int_a, fpu_frac_a, fpu_int_b, fpu_frac_b}),
              96'(0));
        sb.delete();
        ptr_m      = '0;
        prev_start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [1:0] op, input logic [16:0] a, input logic [16:0] b);
        op_v[i] = op;
        a_v[i]  = a;
        b_v[i]  = b;
    endtask

    int base;
    int gb;
    int exp_ord [5];

    initial begin
        req  = '0;
        hold = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 2'(i), 17'(32'h1111 * (i + 1)), 17'(32'h0F0F + i));
        do_reset();

        // Single requester 1: 3.5 + 1.25
        set_op(1, 2'b00, {1'b0, 8'd3, 8'h80}, {1'b0, 8'd1, 8'h40});
        fpu_delay = 5;
        req[1] = 1'b1;
        tick();
        check("t1_ack", 96'(ack), 96'(4'b0010));
        check("t1_busy", 96'(busy), 96'(1));
        tick();
        check("t1_ack_one_cycle", 96'(ack), 96'(0));
        check("t1_start", 96'(fpu_start), 96'(1));
        check("t1_int_a", 96'(fpu_int_a), 96'(3));
        check("t1_frac_a", 96'(fpu_frac_a), 96'(8'h80));
        wait_rsp(1, 40);
        check("t1_result", 96'(rsp_result), 96'(32'h000004C0));
        check("t1_err", 96'(rsp_err), 96'(0));
        tick();
        check("t1_idle", 96'(busy), 96'(0));

        // All four held high from reset: 0,1,2,3,0
        do_reset();
        fpu_delay = 2;
        hold = 1'b1;
        req  = 4'b1111;
        base = rsp_cnt;
        gb   = grants.size();
        wait_rsp(base + 5, 100);
        req  = '0;
        hold = 1'b0;
        exp_ord = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            check($sformatf("rr_order_%0d", k), 96'(grants.size() > gb + k ? grants[gb + k] : -1), 96'(exp_ord[k]));
        tick();
        tick();

        // Pointer at 2 (one grant of requester 1 first), then req=1011 -> 3,0,1
        req[1] = 1'b1;
        base = rsp_cnt;
        wait_rsp(base + 1, 40);
        tick();
        req  = 4'b1011;
        gb   = grants.size();
        wait_rsp(base + 4, 100);
        exp_ord = '{0, 3, 0, 1, 0};
        for (int k = 1; k < 4; k++)
            check($sformatf("ptr2_order_%0d", k), 96'(grants.size() > gb + k - 1 ? grants[gb + k - 1] : -1), 96'(exp_ord[k]));
        tick();

        // FPU never answers: timeout error, then a stray done in IDLE is ignored
        fpu_never = 1'b1;
        req[2] = 1'b1;
        base = rsp_cnt;
        wait_rsp(base + 1, 120);
        fpu_never = 1'b0;
        tick();
        tick();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        repeat (4) tick();
        check("stray_done_no_rsp", 96'(rsp_cnt), 96'(base + 1));
        check("timeout_result_held", 96'(rsp_result), 96'(0));
        check("timeout_err_held", 96'(rsp_err), 96'(1));

        // Done on the final watchdog cycle wins; one cycle later is a timeout
        fpu_delay = TIMEOUT - 1;
        set_op(3, 2'b10, {1'b1, 8'h12, 8'h34}, {1'b0, 8'h56, 8'h78});
        req[3] = 1'b1;
        wait_rsp(base + 2, 120);
        check("edge_done_err", 96'(rsp_err), 96'(0));
        check("edge_done_result", 96'(rsp_result), 96'(fmodel(2'b10, {1'b1, 8'h12, 8'h34}, {1'b0, 8'h56, 8'h78})));
        tick();
        fpu_delay = TIMEOUT;
        req[3] = 1'b1;
        wait_rsp(base + 3, 120);
        check("late_done_err", 96'(rsp_err), 96'(1));
        repeat (3) tick();
        check("late_done_no_rsp", 96'(rsp_cnt), 96'(base + 3));

        // Reset during WAIT aborts silently; pointer restarts at 0
        fpu_never = 1'b1;
        req[0] = 1'b1;
        repeat (10) tick();
        check("abort_in_wait_busy", 96'(busy), 96'(1));
        base = rsp_cnt;
        do_reset();
        fpu_never = 1'b0;
        fpu_delay = 3;
        set_op(0, 2'b00, {1'b0, 8'd10, 8'h01}, {1'b0, 8'd20, 8'h02});
        req = 4'b1001;
        gb  = grants.size();
        wait_rsp(base + 2, 60);
        check("post_reset_first", 96'(grants.size() > gb ? grants[gb] : -1), 96'(0));
        check("post_reset_second", 96'(grants.size() > gb + 1 ? grants[gb + 1] : -1), 96'(3));
        repeat (3) tick();
        check("sb_drained", 96'(sb.size()), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
